// File: rtl/ofm_axis_reader.sv
// ofm_axis_reader: read-side controller for the OFM buffer. Fetches 4-element
// words from the buffer and streams them out as AXI4-Stream beats, with
// backpressure, TLAST on the final beat and a start/busy/done handshake.
module ofm_axis_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 2304,
  parameter int ADDR_W     = 12
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [9:0]              len_words,
  output logic                    busy,
  output logic                    done,
  output logic                    buf_ce,
  output logic                    buf_we,
  output logic [ADDR_W-1:0]       buf_addr,
  input  logic [DATA_WIDTH*4-1:0] buf_q,
  output logic [DATA_WIDTH*4-1:0] m_axis_tdata,
  output logic [3:0]              m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast
);

  localparam int         BEAT_W    = DATA_WIDTH * 4;
  localparam logic [9:0] MAX_BEATS = 10'(DATA_DEPTH / 4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   last_addr;
  logic [BEAT_W-1:0]   tdata_q;
  logic                tvalid_q;
  logic                tlast_q;
  logic [9:0]          clamped_len;
  logic                accept;
  logic                load;
  logic                fetch;
  logic                handshake;

  // Requests longer than the buffer holds are clamped to a full buffer.
  assign clamped_len = (len_words > MAX_BEATS) ? MAX_BEATS : len_words;

  // The output register can take a new word when empty or being emptied.
  assign load      = !tvalid_q || m_axis_tready;
  assign fetch     = (state == S_RUN) && load;
  assign handshake = tvalid_q && m_axis_tready;
  assign accept    = (state == S_IDLE) && start && (len_words != 10'd0);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state <= state_next;
    end
  end

  // Next-state logic and handshake/buffer-control outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    buf_ce     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_next = (len_words == 10'd0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy   = 1'b1;
        buf_ce = load;
        if (fetch && (rd_addr == last_addr)) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (handshake && tlast_q) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Read address pointer and the address of the final word of this drain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_addr   <= '0;
      last_addr <= '0;
    end else if (accept) begin
      rd_addr   <= '0;
      last_addr <= ADDR_W'(clamped_len - 10'd1) << 2;
    end else if (fetch) begin
      rd_addr   <= rd_addr + ADDR_W'(4);
    end
  end

  // Stream output register: loads on fetch, empties on a handshake, and
  // otherwise holds data and last stable while stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else if (fetch) begin
      tdata_q  <= buf_q;
      tvalid_q <= 1'b1;
      tlast_q  <= (rd_addr == last_addr);
    end else if (handshake) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end
  end

  // The pointer only moves on a fetch, so it doubles as the held address.
  assign buf_addr      = rd_addr;
  assign buf_we        = 1'b0;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tkeep  = tvalid_q ? 4'hF : 4'h0;

endmodule

// File: tb/tb_ofm_axis_reader.sv
// Testbench for ofm_axis_reader: models the OFM buffer as a byte array and
// derives every expected beat directly from its contents.
module tb_ofm_axis_reader;

  localparam int DEPTH = 2304;
  localparam int MAXB  = DEPTH / 4;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [9:0]  len_words;
  logic        busy;
  logic        done;
  logic        buf_ce;
  logic        buf_we;
  logic [11:0] buf_addr;
  logic [31:0] buf_q;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;

  logic [7:0]  mem [0:DEPTH-1];

  int vectors;
  int miscompares;

  ofm_axis_reader #(.DATA_WIDTH(8), .DATA_DEPTH(DEPTH), .ADDR_W(12)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .len_words    (len_words),
    .busy         (busy),
    .done         (done),
    .buf_ce       (buf_ce),
    .buf_we       (buf_we),
    .buf_addr     (buf_addr),
    .buf_q        (buf_q),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: element at addr in [31:24], addr+3 in [7:0]; garbage when
  // not enabled so an unrequested capture is visible.
  always_comb begin
    buf_q = 32'hDEAD_BEEF;
    if (buf_ce && (int'(buf_addr) + 3 < DEPTH))
      buf_q = {mem[buf_addr], mem[buf_addr + 12'd1],
               mem[buf_addr + 12'd2], mem[buf_addr + 12'd3]};
  end

  function automatic logic [31:0] exp_word(input int k);
    return {mem[4*k], mem[4*k+1], mem[4*k+2], mem[4*k+3]};
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
  endtask

  // Runs one drain and checks it against the buffer contents.
  // mode 0: tready always 1; 1: pattern 1,0,0; 2: random.
  // inject_at: cycle at which a stray start (len 3) is pulsed, -1 for none.
  task automatic run_drain(input int len, input int mode, input int inject_at,
                           input bit idle_check);
    int n;
    int got;
    int fetched;
    int cyc;
    int limit;
    int first_cyc;
    int last_cyc;
    int final_cyc;
    bit done_seen;
    bit prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    n          = (len > MAXB) ? MAXB : len;
    got        = 0;
    fetched    = 0;
    cyc        = 0;
    limit      = 4 * n + 40;
    first_cyc  = -1;
    last_cyc   = -1;
    final_cyc  = -1;
    done_seen  = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;

    @(negedge clk);
    start = 1'b1;
    len_words = 10'(len);
    m_axis_tready = 1'b0;
    @(negedge clk);
    start = 1'b0;

    if (n == 0) begin
      #1;
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || m_axis_tvalid !== 1'b0 || buf_ce !== 1'b0) begin
        miscompares++;
        $display("FAIL len0_done: done=%b busy=%b tvalid=%b ce=%b, required 1 0 0 0",
                 done, busy, m_axis_tvalid, buf_ce);
      end
      @(negedge clk); #1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL len0_after: done=%b busy=%b tvalid=%b, required 0 0 0",
                 done, busy, m_axis_tvalid);
      end
      return;
    end

    while (!done_seen && cyc < limit) begin
      case (mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (cyc % 3 == 0);
        default: m_axis_tready = 1'($urandom);
      endcase
      start = (cyc == inject_at);
      if (cyc == inject_at) len_words = 10'd3;
      #1;

      vectors++;
      if (buf_we !== 1'b0 || m_axis_tkeep !== (m_axis_tvalid ? 4'hF : 4'h0)) begin
        miscompares++;
        $display("FAIL we_keep cyc %0d: we=%b keep=%h tvalid=%b", cyc, buf_we, m_axis_tkeep, m_axis_tvalid);
      end

      if (cyc == 0) begin
        vectors++;
        if (buf_ce !== 1'b1 || buf_addr !== 12'd0) begin
          miscompares++;
          $display("FAIL first_fetch: ce=%b addr=%0d, required 1 0", buf_ce, buf_addr);
        end
      end

      if (got < n) begin
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          miscompares++;
          $display("FAIL busy cyc %0d: busy=%b done=%b, required 1 0", cyc, busy, done);
        end
      end

      if (prev_stall) begin
        vectors++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
          miscompares++;
          $display("FAIL stall_hold cyc %0d: tvalid=%b tdata=%h tlast=%b, required 1 %h %b",
                   cyc, m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
        end
      end

      if (buf_ce === 1'b1) begin
        vectors++;
        if (fetched >= n || buf_addr !== 12'(4 * fetched)) begin
          miscompares++;
          $display("FAIL fetch_addr: addr=%0d fetch#%0d, required %0d of %0d",
                   buf_addr, fetched, 4 * fetched, n);
        end
        fetched++;
      end

      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        vectors++;
        if (got >= n) begin
          miscompares++;
          $display("FAIL extra_beat: beat %0d data=%h, only %0d required", got, m_axis_tdata, n);
        end else if (m_axis_tdata !== exp_word(got) || m_axis_tlast !== (got == n - 1)) begin
          miscompares++;
          $display("FAIL beat %0d: tdata=%h tlast=%b, required %h %b",
                   got, m_axis_tdata, m_axis_tlast, exp_word(got), (got == n - 1));
        end
        if (got == 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
        if (got == n) final_cyc = cyc;
      end

      if (got >= n && final_cyc >= 0 && cyc == final_cyc + 1) begin
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
          miscompares++;
          $display("FAIL done_pulse: done=%b busy=%b tvalid=%b, required 1 0 0",
                   done, busy, m_axis_tvalid);
        end
        done_seen = 1'b1;
      end else if (done === 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL early_done: done=1 at cyc %0d with %0d of %0d beats", cyc, got, n);
      end

      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (!done_seen) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;

    vectors++;
    if (!done_seen || got != n || fetched != n) begin
      miscompares++;
      $display("FAIL drain_len%0d: beats=%0d fetches=%0d done=%b, required %0d %0d 1",
               len, got, fetched, done_seen, n, n);
    end

    if (mode == 0) begin
      vectors++;
      if (last_cyc - first_cyc != n - 1) begin
        miscompares++;
        $display("FAIL throughput: %0d beats over %0d cycles, required %0d",
                 n, last_cyc - first_cyc + 1, n);
      end
    end

    if (idle_check) begin
      for (int i = 0; i < 2; i++) begin
        @(negedge clk); #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || m_axis_tvalid !== 1'b0 || buf_ce !== 1'b0) begin
          miscompares++;
          $display("FAIL idle_after: done=%b busy=%b tvalid=%b ce=%b, required 0 0 0 0",
                   done, busy, m_axis_tvalid, buf_ce);
        end
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    start = 1'b0;
    len_words = '0;
    m_axis_tready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, buf_ce, buf_we, buf_addr, m_axis_tdata, m_axis_tkeep,
         m_axis_tvalid, m_axis_tlast} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b ce=%b we=%b addr=%h tdata=%h keep=%h tvalid=%b tlast=%b, required all 0",
               busy, done, buf_ce, buf_we, buf_addr, m_axis_tdata, m_axis_tkeep,
               m_axis_tvalid, m_axis_tlast);
    end
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    fill_ramp();
    run_drain(4, 0, -1, 1'b1);
  endtask

  task automatic test_backpressure();
    fill_random();
    run_drain(8, 1, -1, 1'b1);
  endtask

  task automatic test_edge_lengths();
    fill_random();
    run_drain(0, 0, -1, 1'b1);
    run_drain(1, 0, -1, 1'b1);
    run_drain(700, 0, -1, 1'b1);
  endtask

  task automatic test_ignored_start();
    fill_random();
    run_drain(10, 1, 6, 1'b1);
  endtask

  task automatic test_reset_mid();
    int got;
    int cyc;
    fill_ramp();
    got = 0;
    cyc = 0;
    @(negedge clk);
    start = 1'b1;
    len_words = 10'd10;
    m_axis_tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (got < 3 && cyc < 50) begin
      #1;
      if (m_axis_tvalid && m_axis_tready) got++;
      @(negedge clk);
      cyc++;
    end
    m_axis_tready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    vectors++;
    if (got != 3 || m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset: beats=%0d tvalid=%b busy=%b, required 3 1 1", got, m_axis_tvalid, busy);
    end
    #1;
    rstn = 1'b0;
    #1;
    vectors++;
    if ({busy, done, buf_ce, buf_we, buf_addr, m_axis_tdata, m_axis_tkeep,
         m_axis_tvalid, m_axis_tlast} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: busy=%b done=%b ce=%b addr=%h tdata=%h keep=%h tvalid=%b tlast=%b, required all 0",
               busy, done, buf_ce, buf_addr, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast);
    end
    @(negedge clk);
    rstn = 1'b1;
    run_drain(2, 0, -1, 1'b1);
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_drain(5, 0, -1, 1'b0);
    run_drain(3, 2, -1, 1'b1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 5; t++) begin
      fill_random();
      run_drain(int'($urandom_range(1, 60)), 2, -1, 1'b1);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_edge_lengths();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ofm_axis_reader.md
# ofm_axis_reader

Drains the output-feature-map buffer after a layer finishes and streams its contents to the AXI DMA S2MM channel as 32-bit AXI4-Stream beats. It is the read-side controller for the OFM buffer: it drives the buffer's `ce`/`we`/`addr` port in read mode and captures the 4-byte read word. It also handles stream backpressure, TLAST generation and the start/busy/done handshake with the layer sequencer.

## Interface
Parameters:
- `DATA_WIDTH`, 8: bits per buffer element; beat width is `DATA_WIDTH*4`.
- `DATA_DEPTH`, 2304: buffer depth in elements; maximum beat count is `DATA_DEPTH/4` (576).
- `ADDR_W`, 12: buffer address width.

Ports:
- `clk`, in, 1: single clock for the whole block.
- `rstn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle request to begin a drain. Sampled only in IDLE.
- `len_words`, in, 10: number of 32-bit beats to send. Sampled with `start`.
- `busy`, out, 1: high from the accepted start until the final handshake.
- `done`, out, 1: one-cycle pulse after the final handshake.
- `buf_ce`, out, 1: buffer enable; high only in fetch cycles.
- `buf_we`, out, 1: buffer write enable; constant 0 (read mode).
- `buf_addr`, out, `ADDR_W`: buffer element address of the fetched word.
- `buf_q`, in, `DATA_WIDTH*4`: buffer read data, combinational from `buf_addr`/`buf_ce`. Bits [31:24] hold the element at `buf_addr`, bits [7:0] the element at `buf_addr+3`.
- `m_axis_tdata`, out, `DATA_WIDTH*4`: stream data, equal to `buf_q` as captured.
- `m_axis_tkeep`, out, 4: constant 4'hF while `m_axis_tvalid` is high, 0 otherwise.
- `m_axis_tvalid`, out, 1: stream valid.
- `m_axis_tready`, in, 1: stream ready.
- `m_axis_tlast`, out, 1: high on the final beat only.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: issues fetches.
  - DRAIN: all words fetched; waits for the final handshake.
  - DONE: one cycle; `done`=1.
- IDLE, `start`=1, `len_words`=0 → DONE directly. No beat is sent and `busy` stays 0.
- IDLE, `start`=1, `len_words`>0 → RUN:
  - Latch count = min(`len_words`, 576).
  - Set `rd_addr`=0 and `sent`=0.
- Load condition: `load` = !`m_axis_tvalid` || `m_axis_tready`.
- Fetch (RUN only): in any cycle with `load`=1, drive `buf_ce`=1 and `buf_addr`=`rd_addr`.
  - At the next edge, `buf_q` goes into `m_axis_tdata`, `m_axis_tvalid` goes to 1, and `rd_addr` advances by 4.
  - When `load`=0, `buf_ce`=0 and `buf_addr` holds its value.
- The output register holds `tdata`/`tlast` stable while `tvalid`=1 and `tready`=0. No data is dropped or duplicated.
- `m_axis_tlast` is set together with the word fetched at `rd_addr` = 4·(count−1).
- Fetching the last word moves RUN → DRAIN.
- DRAIN: no fetches. When `tvalid`&`tready`&`tlast`, the next edge clears `tvalid` and moves to DONE.
- DONE → IDLE after one cycle. `busy`=0 in IDLE and DONE.
- When no new fetch occurs, a handshake (`tvalid`&`tready`) at the edge clears `tvalid`.
- `start` while `busy` is ignored.
- `rd_addr` never exceeds 4·575 = 2300, so no address wrap.
- `len_words` > 576 is clamped to 576 beats.

## Timing
- Reset values: every output is 0 (`busy`, `done`, `buf_ce`, `buf_we`, `buf_addr`, `m_axis_*`), and state is IDLE.
- Reset asserted mid-drain takes effect immediately. Any pending beat is discarded and `tvalid` drops asynchronously.
- Latency:
  - `start` sampled at edge E0 → fetch of addr 0 in cycle E0–E1 → `tvalid`=1 after E1.
  - `busy`=1 after E0.
- Throughput: with `tready` held 1, N beats are delivered in N consecutive cycles.
- `done` pulses one cycle after the edge that completes the tlast handshake, i.e. the first cycle with `busy`=0.
- `tvalid` never deasserts without a handshake. `tdata`, `tlast` and `tkeep` are stable while stalled.
- `buf_ce` is 1 only in cycles where a word is captured at the next edge.

## Test plan
- Basic drain: preload buffer element i = i[7:0], `len_words`=4, `tready`=1 → beats 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F on 4 consecutive cycles. `tlast` on beat 4; `done` pulses 1 cycle later.
- Backpressure: `len_words`=8, `tready` toggling 1,0,0,1,… → same 8 words in order, no repeats or losses. `tdata` stable during stalls; exactly one `tlast`.
- Edge lengths:
  - `len_words`=0 → `done` pulses once, no `tvalid`, `busy` stays 0.
  - `len_words`=1 → a single beat with `tlast`=1.
  - `len_words`=700 → 576 beats, last from addr 2300.
- Ignored start: pulse `start` with `len_words`=3 mid-drain of 10 → exactly 10 beats; no second drain.
- Reset mid-drain: deassert `rstn` after beat 3 of 10 with `tready`=0 → all outputs 0 immediately. A new `start` with `len_words`=2 after reset sends addrs 0 and 4.
- Back-to-back: `start` in the cycle after `done` → second drain begins normally with correct data and `tlast`.
